// File: rtl/csr_pkg.sv
// Shared constants for the Zicsr unit: funct3 encodings, RMW op codes and the
// read-only counter address map.
package csr_pkg;

  localparam logic [2:0] CSRRW  = 3'b001;
  localparam logic [2:0] CSRRS  = 3'b010;
  localparam logic [2:0] CSRRC  = 3'b011;
  localparam logic [2:0] CSRRWI = 3'b101;
  localparam logic [2:0] CSRRSI = 3'b110;
  localparam logic [2:0] CSRRCI = 3'b111;

  localparam logic [1:0] OP_RW = 2'b01;
  localparam logic [1:0] OP_RS = 2'b10;
  localparam logic [1:0] OP_RC = 2'b11;

  localparam logic [11:0] ADDR_CYCLE    = 12'hC00;
  localparam logic [11:0] ADDR_TIME     = 12'hC01;
  localparam logic [11:0] ADDR_INSTRET  = 12'hC02;
  localparam logic [11:0] ADDR_CYCLEH   = 12'hC80;
  localparam logic [11:0] ADDR_TIMEH    = 12'hC81;
  localparam logic [11:0] ADDR_INSTRETH = 12'hC82;

endpackage

// File: rtl/csr_counter.sv
// Free-running wrap-around counter with enable; used for cycle/time and instret.
module csr_counter #(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      count <= '0;
    else if (en)
      count <= count + W'(1);
  end

endmodule

// File: rtl/csr_unit.sv
// Zicsr execute unit in EX: combinational read/decode, tohost register written
// on the edge that advances the instruction, and cycle/instret counters.
module csr_unit
  import csr_pkg::*;
#(
  parameter int          XLEN        = 32,
  parameter int          CNT_W       = 64,
  parameter logic [11:0] TOHOST_ADDR = 12'h51E
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            csr_valid,
  input  logic [2:0]      csr_funct3,
  input  logic [11:0]     csr_addr,
  input  logic [4:0]      csr_rs1_addr,
  input  logic [XLEN-1:0] csr_rs1_data,
  input  logic            retire,
  output logic [XLEN-1:0] csr_rdata,
  output logic            csr_illegal,
  output logic [XLEN-1:0] csr,
  output logic            tohost_valid
);

  generate
    if (CNT_W != 32 && CNT_W != 64) begin : g_bad_cnt_w
      $error("csr_unit: CNT_W must be 32 or 64");
    end
  endgenerate

  function automatic logic [XLEN-1:0] csr_rmw(input logic [1:0] op,
                                              input logic [XLEN-1:0] old,
                                              input logic [XLEN-1:0] src);
    case (op)
      OP_RW:   return src;
      OP_RS:   return old | src;
      OP_RC:   return old & ~src;
      default: return old;
    endcase
  endfunction

  logic [CNT_W-1:0] cycle_cnt;
  logic [CNT_W-1:0] instret_cnt;
  logic [63:0]      cycle_64;
  logic [63:0]      instret_64;

  // cycle/time never stall; instret only counts retirements that actually advance.
  csr_counter #(.W(CNT_W)) u_cycle_cnt (
    .clk   (clk),
    .reset (reset),
    .en    (1'b1),
    .count (cycle_cnt)
  );

  csr_counter #(.W(CNT_W)) u_instret_cnt (
    .clk   (clk),
    .reset (reset),
    .en    (retire & ~stall),
    .count (instret_cnt)
  );

  // Zero-extending to 64 makes the high halves read 0 when CNT_W is 32.
  assign cycle_64   = 64'(cycle_cnt);
  assign instret_64 = 64'(instret_cnt);

  logic [XLEN-1:0] tohost_q;
  logic [XLEN-1:0] old_val_p0;
  logic [XLEN-1:0] src_p0;
  logic [1:0]      op_p0;
  logic            mapped_p0;
  logic            read_only_p0;
  logic            wr_intent_p0;
  logic            wr_commit_p0;

  assign op_p0        = csr_funct3[1:0];
  assign src_p0       = csr_funct3[2] ? XLEN'(csr_rs1_addr) : csr_rs1_data;
  assign wr_intent_p0 = (op_p0 == OP_RW) || (csr_rs1_addr != 5'd0);

  always_comb begin
    mapped_p0    = 1'b1;
    read_only_p0 = 1'b1;
    old_val_p0   = '0;
    case (csr_addr)
      TOHOST_ADDR: begin
        read_only_p0 = 1'b0;
        old_val_p0   = tohost_q;
      end
      ADDR_CYCLE, ADDR_TIME:   old_val_p0 = XLEN'(cycle_64);
      ADDR_CYCLEH, ADDR_TIMEH: old_val_p0 = XLEN'(cycle_64[63:32]);
      ADDR_INSTRET:            old_val_p0 = XLEN'(instret_64);
      ADDR_INSTRETH:           old_val_p0 = XLEN'(instret_64[63:32]);
      default:                 mapped_p0  = 1'b0;
    endcase
  end

  assign csr_illegal  = csr_valid & ((op_p0 == 2'b00) | ~mapped_p0 |
                                     (wr_intent_p0 & read_only_p0));
  assign csr_rdata    = csr_valid ? old_val_p0 : '0;
  assign wr_commit_p0 = csr_valid & wr_intent_p0 & ~csr_illegal & ~stall;

  // ---- commit edge: instruction leaves EX ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tohost_q     <= '0;
      tohost_valid <= 1'b0;
    end else begin
      tohost_valid <= wr_commit_p0;
      if (wr_commit_p0)
        tohost_q <= csr_rmw(op_p0, old_val_p0, src_p0);
    end
  end

  assign csr = tohost_q;

endmodule
